// File: rtl/seq_piso_tx.sv
// Parallel-in serial-out frame transmitter: start bit, data LSB-first, optional parity, stop bit.
// Optional parity stage is built only when SEQ_PISO_PARITY_EN is defined.
module seq_piso_tx #(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 4,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic             d_ready,
  output logic             q,
  output logic             busy,
  output logic             done
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3
`ifdef SEQ_PISO_PARITY_EN
    , S_PARITY = 3'd4
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cyc_q, cyc_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic             done_q, done_d;
  logic             cyc_wrap;

`ifdef SEQ_PISO_PARITY_EN
  logic par_q, par_d;

  function automatic logic frame_parity(input logic [WIDTH-1:0] w);
    return (^w) ^ PARITY_ODD;
  endfunction
`else
  localparam bit unused_parity_odd = PARITY_ODD;
`endif

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cyc_d    = cyc_q;
    bit_d    = bit_q;
    done_d   = 1'b0;
`ifdef SEQ_PISO_PARITY_EN
    par_d    = par_q;
`endif
    cyc_wrap = (cyc_q == CYC_LAST);
    // Bit timer free-runs in every non-idle state and wraps at the end of each bit.
    if (state_q != S_IDLE) begin
      cyc_d = cyc_wrap ? '0 : cyc_q + 1'b1;
    end
    case (state_q)
      S_IDLE: begin
        if (d_valid) begin
          state_d = S_START;
          shreg_d = d;
          cyc_d   = '0;
          bit_d   = '0;
`ifdef SEQ_PISO_PARITY_EN
          par_d   = frame_parity(d);
`endif
        end
      end
      S_START: begin
        if (cyc_wrap) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (cyc_wrap) begin
          shreg_d = shreg_q >> 1;
          if (bit_q == BIT_LAST) begin
`ifdef SEQ_PISO_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
`ifdef SEQ_PISO_PARITY_EN
      S_PARITY: begin
        if (cyc_wrap) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (cyc_wrap) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      cyc_q   <= '0;
      bit_q   <= '0;
      done_q  <= 1'b0;
`ifdef SEQ_PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      done_q  <= done_d;
`ifdef SEQ_PISO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Line level is decoded from registered state only.
  always_comb begin
    q = 1'b1;
    case (state_q)
      S_START:  q = 1'b0;
      S_DATA:   q = shreg_q[0];
`ifdef SEQ_PISO_PARITY_EN
      S_PARITY: q = par_q;
`endif
      default:  q = 1'b1;
    endcase
  end

  assign busy    = (state_q != S_IDLE);
  assign d_ready = (state_q == S_IDLE);
  assign done    = done_q;

endmodule

// File: tb/tb_seq_piso_tx.sv
// Bench for seq_piso_tx: table of words with expected parity, serial-line scoreboard,
// plus hand sequences for back-to-back, mid-frame reset and the 1-bit/1-cycle corner.
module tb_seq_piso_tx;

  localparam int W     = 8;
  localparam int BC    = 4;
  localparam bit P_ODD = 1'b0;
`ifdef SEQ_PISO_PARITY_EN
  localparam int FRAME_CYC = (W + 3) * BC;
`else
  localparam int FRAME_CYC = (W + 2) * BC;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, d_valid;
  logic [W-1:0] d;
  logic         d_ready, q, busy, done;

  logic         rst1, v1;
  logic [0:0]   d1;
  logic         r1, q1, b1, dn1;

  seq_piso_tx #(.WIDTH(W), .BIT_CYCLES(BC), .PARITY_ODD(P_ODD)) dut (
    .clk(clk), .rst(rst), .d(d), .d_valid(d_valid),
    .d_ready(d_ready), .q(q), .busy(busy), .done(done)
  );

  seq_piso_tx #(.WIDTH(1), .BIT_CYCLES(1), .PARITY_ODD(1'b1)) dut1 (
    .clk(clk), .rst(rst1), .d(d1), .d_valid(v1),
    .d_ready(r1), .q(q1), .busy(b1), .done(dn1)
  );

  typedef struct {
    logic [W-1:0] d;
    logic         par_even;
  } vec_t;

  vec_t vecs[6];
  vec_t pend[$];
  logic bitq[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;
  bit   end_pending = 1'b0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    logic exp_q, exp_done, exp_busy;
    exp_done    = end_pending;
    end_pending = 1'b0;
    exp_busy    = (bitq.size() > 0);
    exp_q       = 1'b1;
    if (exp_busy) begin
      exp_q = bitq.pop_front();
      if (bitq.size() == 0) end_pending = 1'b1;
    end
    chk1("done", done, exp_done);
    chk1("busy", busy, exp_busy);
    chk1("d_ready", d_ready, !exp_busy);
    chk1("q", q, exp_q);
  endtask

  task automatic push_frame(input vec_t v);
    for (int c = 0; c < BC; c++) bitq.push_back(1'b0);
    for (int i = 0; i < W; i++)
      for (int c = 0; c < BC; c++) bitq.push_back(v.d[i]);
`ifdef SEQ_PISO_PARITY_EN
    for (int c = 0; c < BC; c++) bitq.push_back(v.par_even ^ P_ODD);
`endif
    for (int c = 0; c < BC; c++) bitq.push_back(1'b1);
  endtask

  // One clock: check outputs at the falling edge, predict what the next rising edge does.
  task automatic cycle();
    vec_t v;
    @(negedge clk);
    if (mon_en) monitor();
    if (rst) begin
      bitq.delete();
      end_pending = 1'b0;
    end else if (d_valid && d_ready === 1'b1) begin
      if (pend.size() == 0) begin
        chk1("unexpected_accept", 1'b1, 1'b0);
      end else begin
        v = pend.pop_front();
        push_frame(v);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input vec_t v);
    pend.push_back(v);
    d       = v.d;
    d_valid = 1'b1;
    cycle();
    d_valid = 1'b0;
    d       = W'($urandom);
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((bitq.size() != 0 || busy !== 1'b0) && k < 200) begin
      cycle();
      k++;
    end
    chk1("idle_timeout", logic'(k < 200), 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    vecs[0] = '{8'hA5, 1'b0};
    vecs[1] = '{8'h01, 1'b1};
    vecs[2] = '{8'hFF, 1'b0};
    vecs[3] = '{8'h3C, 1'b0};
    vecs[4] = '{8'h80, 1'b1};
    vecs[5] = '{8'h00, 1'b0};

    rst = 1'b1; d_valid = 1'b0; d = '0;
    rst1 = 1'b1; v1 = 1'b0; d1 = 1'b0;
    cycle();
    mon_en = 1'b1;
    cycle();
    rst = 1'b0; rst1 = 1'b0;

    repeat (10) cycle();

    for (int i = 0; i < 6; i++) begin
      send(vecs[i]);
      wait_idle();
      repeat (2) cycle();
    end

    // Back-to-back with d_valid held; d changes during the first frame.
    pend.push_back('{8'h01, 1'b1});
    pend.push_back('{8'hFF, 1'b0});
    d = 8'h01;
    d_valid = 1'b1;
    cycle();
    d = 8'hFF;
    k = 0;
    while (pend.size() != 0 && k < 100) begin
      cycle();
      k++;
    end
    chk_int("b2b_gap", k, FRAME_CYC + 1);
    d_valid = 1'b0;
    wait_idle();
    repeat (2) cycle();

    // Reset during data bit 3 abandons the frame.
    send('{8'hA5, 1'b0});
    repeat (17) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk1("abort_q", q, 1'b1);
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_ready", d_ready, 1'b1);
    chk1("abort_done", done, 1'b0);
    repeat (5) cycle();
    send('{8'h3C, 1'b0});
    wait_idle();
    repeat (2) cycle();

    // WIDTH=1, BIT_CYCLES=1 instance.
    chk1("w1_ready_idle", r1, 1'b1);
    d1 = 1'b0;
    v1 = 1'b1;
    cycle();
    v1 = 1'b0;
    d1 = 1'b1;
    chk1("w1_start", q1, 1'b0);
    chk1("w1_busy", b1, 1'b1);
    chk1("w1_ready_busy", r1, 1'b0);
    cycle();
    chk1("w1_data", q1, 1'b0);
`ifdef SEQ_PISO_PARITY_EN
    cycle();
    chk1("w1_parity", q1, 1'b1);
`endif
    cycle();
    chk1("w1_stop", q1, 1'b1);
    chk1("w1_no_early_done", dn1, 1'b0);
    cycle();
    chk1("w1_done", dn1, 1'b1);
    chk1("w1_idle_busy", b1, 1'b0);
    chk1("w1_idle_ready", r1, 1'b1);
    cycle();
    chk1("w1_done_single", dn1, 1'b0);

    chk_int("pending_left", pend.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
